gcd_sequencer: RTL and testbench
================================

GCD_SEQUENCER -- requirements
Module: gcd_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to compute GCD; sampled only in IDLE.
REQ-004 SHALL have ports gt, lt, eq, input, 1 each, combinational comparator flags from datapath (A>B, A<B, A==B).
REQ-005 SHALL have ports ldA, ldB, output, 1 each, load enables for datapath registers A and B.
REQ-006 SHALL have port sel_in, output, 1, bus source: 1 = external data, 0 = subtractor result.
REQ-007 SHALL have ports sel1, sel2, output, 1 each, subtractor operand selects: sel1 1 = X=A / 0 = X=B; sel2 1 = Y=A / 0 = Y=B; result = X−Y.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when GCD is in register A.
REQ-010 SHALL have port iter, output, 8, count of subtract cycles of current or last run, saturating at 255.
REQ-011 SHALL have port err, output, 1, high with done when run aborted by timeout (see Configuration).

Function
REQ-012 SHALL implement states IDLE, LOAD_A, LOAD_B, CMP, DONE.
REQ-013 IDLE: all control outputs 0; start=1 -> LOAD_A, iter cleared to 0, err cleared to 0.
REQ-014 LOAD_A: ldA=1, sel_in=1; upstream SHALL hold operand A on data this cycle; -> LOAD_B.
REQ-015 LOAD_B: ldB=1, sel_in=1; upstream SHALL hold operand B on data this cycle; -> CMP.
REQ-016 CMP (Mealy on flags, sel_in=0): gt -> ldA=1, sel1=1, sel2=0 (A<=A−B), iter+1, stay CMP.
REQ-017 CMP: lt -> ldB=1, sel1=0, sel2=1 (B<=B−A), iter+1, stay CMP.
REQ-018 CMP: eq -> no loads, -> DONE; eq SHALL take priority if multiple flags are high.
REQ-019 CMP: no flag high (illegal) -> no loads, stay CMP.
REQ-020 DONE: done=1 for exactly one cycle, busy=1, -> IDLE; result is read from register A.
REQ-021 start while busy=1 SHALL be ignored; start held high through DONE SHALL launch a new run from IDLE on the following cycle.
REQ-022 iter SHALL hold its value from DONE until the next accepted start; increments beyond 255 SHALL leave it at 255.
REQ-023 Latency: done SHALL be high in cycle 4+N after the start-sampling cycle, where N = final iter.
REQ-024 ldA and ldB SHALL never be high in the same cycle.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE; ldA, ldB, sel_in, sel1, sel2, busy, done, err = 0, iter = 0 after that edge.
REQ-026 rst SHALL override start and any in-flight run; no done pulse SHALL follow a reset-aborted run; datapath contents are undefined to consumers.

Configuration
REQ-027 Macro GCD_SEQ_TIMEOUT_EN defined: in CMP with iter == 255 and eq=0, SHALL go to DONE with err=1 alongside done; guarantees termination for zero operands.
REQ-028 Macro GCD_SEQ_TIMEOUT_EN undefined: no timeout; err tied 0; a zero operand with nonzero partner SHALL keep the FSM in CMP until rst.

Verification
REQ-029 data 48 then 18, start pulse -> ldA/sel1=1/sel2=0 ×3, ldB/sel1=0/sel2=1 ×1; done in cycle 8; iter=4; A=6; err=0.
REQ-030 data 9 then 27 -> two ldB subtracts; done in cycle 6; iter=2; A=9.
REQ-031 data 7 then 7 -> no subtracts; done in cycle 4; iter=0.
REQ-032 start pulsed again during CMP of a 48/18 run -> ignored; single done pulse; iter=4.
REQ-033 rst=1 in 2nd CMP cycle of 48/18 run -> next cycle IDLE, all outputs 0, no done; new start runs cleanly.
REQ-034 GCD_SEQ_TIMEOUT_EN defined, data 5 then 0 -> done with err=1, iter=255, done in cycle 259.

Source files
------------

// File: rtl/gcd_sequencer.sv
// Control FSM for a subtractive GCD datapath: loads A and B, then subtracts the
// smaller from the larger until equal. Optional timeout enabled by GCD_SEQ_TIMEOUT_EN.
module gcd_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gt,
  input  logic       lt,
  input  logic       eq,
  output logic       ldA,
  output logic       ldB,
  output logic       sel_in,
  output logic       sel1,
  output logic       sel2,
  output logic       busy,
  output logic       done,
  output logic [7:0] iter,
  output logic       err
);

  // state  | meaning
  // IDLE   | waiting for start, all controls low
  // LOAD_A | external data into A
  // LOAD_B | external data into B
  // CMP    | subtract smaller from larger until eq (Mealy on flags)
  // DONE   | one-cycle done pulse, GCD in A
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CMP, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] iter_nxt;
  logic [7:0] iter_inc;
  logic       err_q, err_nxt;
  logic       timeout;

`ifdef GCD_SEQ_TIMEOUT_EN
  assign timeout = (iter == 8'hFF);
`else
  assign timeout = 1'b0;
`endif

  assign iter_inc = (iter == 8'hFF) ? iter : iter + 8'd1;
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      iter  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      iter  <= iter_nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter;
    err_nxt   = err_q;
    ldA       = 1'b0;
    ldB       = 1'b0;
    sel_in    = 1'b0;
    sel1      = 1'b0;
    sel2      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_A;
          iter_nxt  = 8'd0;
          err_nxt   = 1'b0;
        end
      end
      LOAD_A: begin
        ldA       = 1'b1;
        sel_in    = 1'b1;
        busy      = 1'b1;
        state_nxt = LOAD_B;
      end
      LOAD_B: begin
        ldB       = 1'b1;
        sel_in    = 1'b1;
        busy      = 1'b1;
        state_nxt = CMP;
      end
      CMP: begin
        busy = 1'b1;
        // eq wins over gt/lt; with no flag high the FSM just waits
        if (eq) begin
          state_nxt = DONE;
        end else if (timeout) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (gt) begin
          ldA      = 1'b1;
          sel1     = 1'b1;
          iter_nxt = iter_inc;
        end else if (lt) begin
          ldB      = 1'b1;
          sel2     = 1'b1;
          iter_nxt = iter_inc;
        end
      end
      DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Directed bench for gcd_sequencer with a behavioural A/B/subtractor datapath.
// Define GCD_SEQ_TIMEOUT_EN on both files to exercise the timeout build.
module tb_gcd_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, gt, lt, eq;
  logic       ldA, ldB, sel_in, sel1, sel2, busy, done, err;
  logic [7:0] iter;
  logic [7:0] opa = 8'd0, opb = 8'd0;
  logic [7:0] reg_a = 8'd0, reg_b = 8'd0;
  logic [7:0] data, x, y, bus;
  int         passed = 0, total = 0;
  int         cyc, na, nb, both, dones;

  always #5 clk = ~clk;

  gcd_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .gt(gt), .lt(lt), .eq(eq),
    .ldA(ldA), .ldB(ldB), .sel_in(sel_in), .sel1(sel1), .sel2(sel2),
    .busy(busy), .done(done), .iter(iter), .err(err)
  );

  // upstream presents operand B only while ldB is asserted
  assign data = ldB ? opb : opa;
  assign x    = sel1 ? reg_a : reg_b;
  assign y    = sel2 ? reg_a : reg_b;
  assign bus  = sel_in ? data : x - y;
  assign gt   = reg_a > reg_b;
  assign lt   = reg_a < reg_b;
  assign eq   = reg_a == reg_b;

  always @(posedge clk) begin
    if (ldA) reg_a <= bus;
    if (ldB) reg_b <= bus;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Start sampled at the first posedge is cycle 0; cyc is the cycle done is seen (-1 if never).
  task automatic run(input logic [7:0] a, input logic [7:0] b, input int budget,
                     input int restart_at, output int c_done, output int n_a,
                     output int n_b, output int n_both);
    opa = a; opb = b;
    n_a = 0; n_b = 0; n_both = 0; c_done = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (ldA && ldB) n_both++;
      if (!sel_in && ldA) n_a++;
      if (!sel_in && ldB) n_b++;
      if (done) begin
        c_done = c;
        break;
      end
      start = (c == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {ldA, ldB, sel_in, sel1, sel2, busy, done, err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset_iter", iter, 0);
    rst = 1'b0;
    @(negedge clk);

    run(8'd48, 8'd18, 40, 0, cyc, na, nb, both);
    check("48_18_cycle", cyc, 8);
    check("48_18_subA", na, 3);
    check("48_18_subB", nb, 1);
    check("48_18_iter", iter, 4);
    check("48_18_A", reg_a, 6);
    check("48_18_err", err, 0);
    check("48_18_both", both, 0);
    @(negedge clk);
    check_quiet("48_18_idle");
    check("48_18_iter_hold", iter, 4);

    run(8'd9, 8'd27, 40, 0, cyc, na, nb, both);
    check("9_27_cycle", cyc, 6);
    check("9_27_subB", nb, 2);
    check("9_27_subA", na, 0);
    check("9_27_iter", iter, 2);
    check("9_27_A", reg_a, 9);
    @(negedge clk);

    run(8'd7, 8'd7, 40, 0, cyc, na, nb, both);
    check("7_7_cycle", cyc, 4);
    check("7_7_iter", iter, 0);
    check("7_7_A", reg_a, 7);
    @(negedge clk);

    run(8'd0, 8'd0, 40, 0, cyc, na, nb, both);
    check("0_0_cycle", cyc, 4);
    @(negedge clk);

    // start pulsed during CMP must be ignored
    run(8'd48, 8'd18, 40, 4, cyc, na, nb, both);
    check("restart_cycle", cyc, 8);
    check("restart_iter", iter, 4);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("restart_single_done", dones, 0);

    // reset in the second CMP cycle aborts the run
    opa = 8'd48; opb = 8'd18;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_cmp", {busy, sel_in}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet("abort");
    check("abort_iter", iter, 0);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort_no_done", dones, 0);

    run(8'd9, 8'd27, 40, 0, cyc, na, nb, both);
    check("after_abort_cycle", cyc, 6);
    check("after_abort_A", reg_a, 9);
    @(negedge clk);

`ifdef GCD_SEQ_TIMEOUT_EN
    run(8'd5, 8'd0, 300, 0, cyc, na, nb, both);
    check("timeout_cycle", cyc, 259);
    check("timeout_err", err, 1);
    check("timeout_iter", iter, 255);
    @(negedge clk);
    check("timeout_err_hold", {busy, err}, 32'd1);
`else
    // zero operand: stuck in CMP, iter saturates, never done
    run(8'd5, 8'd0, 300, 0, cyc, na, nb, both);
    check("stuck_no_done", cyc, -1);
    check("stuck_iter_sat", iter, 255);
    check("stuck_busy", {busy, err}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet("stuck_reset");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
